// File: rtl/rtc_cal_pkg.sv
// Shared types and constants for the seconds-to-calendar converter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rtc_cal_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIV_DAY,
    ST_DIV_HR,
    ST_DIV_MIN,
    ST_DIV_WDAY,
    ST_YEAR,
    ST_MONTH,
    ST_DONE
  } cal_state_e;

  localparam int SEC_PER_DAY   = 86400;
  localparam int SEC_PER_HR    = 3600;
  localparam int SEC_PER_MIN   = 60;
  localparam int DAYS_PER_WEEK = 7;
  localparam int EPOCH_YEAR    = 2000;
  localparam int EPOCH_WDAY    = 6;  // 2000-01-01 was a Saturday

  // Days in a month, month numbered 1..12.
  function automatic logic [4:0] month_len(input logic [3:0] month, input logic leap);
    logic [4:0] len;
    case (month)
      4'd2:                    len = leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: len = 5'd30;
      default:                 len = 5'd31;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/rtc_cal_div.sv
// Sequential restoring divider, one quotient bit per cycle, reused for every divide.
// Latency: start accepted when idle; done_o pulses CNT_WIDTH+1 cycles after the start cycle.
// Backpressure: none; start_i is ignored while busy_o is high, results hold until next start.
// Ports: clk_i/rst_i (sync, active-high), start_i, dividend_i, divisor_i,
//        busy_o, done_o (1-cycle pulse), quot_o, rem_o.
module rtc_cal_div #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] dividend_i,
  input  logic [CNT_WIDTH-1:0] divisor_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] quot_o,
  output logic [CNT_WIDTH-1:0] rem_o
);

  localparam int CW = $clog2(CNT_WIDTH + 1);

  logic [CNT_WIDTH-1:0] quot_q, rem_q, dvsr_q;
  logic [CW-1:0]        cnt_q;
  logic                 done_q;
  logic [CNT_WIDTH:0]   shifted, trial;

  // Remainder is always below the divisor, so one extra bit holds the
  // shifted partial remainder; its MSB after subtraction is the borrow.
  always_comb begin
    shifted = {rem_q, quot_q[CNT_WIDTH-1]};
    trial   = shifted - {1'b0, dvsr_q};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      quot_q <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i && !busy_o) begin
        quot_q <= dividend_i;
        rem_q  <= '0;
        dvsr_q <= divisor_i;
        cnt_q  <= CW'(CNT_WIDTH);
      end else if (busy_o) begin
        if (!trial[CNT_WIDTH]) begin
          rem_q  <= trial[CNT_WIDTH-1:0];
          quot_q <= {quot_q[CNT_WIDTH-2:0], 1'b1};
        end else begin
          rem_q  <= shifted[CNT_WIDTH-1:0];
          quot_q <= {quot_q[CNT_WIDTH-2:0], 1'b0};
        end
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) done_q <= 1'b1;
      end
    end
  end

  assign busy_o = (cnt_q != '0);
  assign done_o = done_q;
  assign quot_o = quot_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/rtc_cal_conv.sv
// Converts an RTC seconds count (epoch 2000-01-01 00:00:00) into calendar fields.
// Latency: 3 or 4 divides of CNT_WIDTH+1 cycles, plus year walk + month walk + 1; max 282 (249 without wday).
// Backpressure: cnt_ready_o only in IDLE (no queueing); result held with cal_valid_o until cal_ready_i.
// Ports: clk_i/rst_i (sync, active-high); cnt_i/cnt_valid_i/cnt_ready_o input handshake;
//        cal_valid_o/cal_ready_i output handshake; year/month/mday/hour/min/sec/wday fields; busy_o.
// Build option: define RTC_CAL_WDAY_EN to compute wday_o (otherwise tied to 0 and the step is skipped).
module rtc_cal_conv
  import rtc_cal_pkg::*;
#(
  parameter int CNT_WIDTH  = 32,
  parameter int YEAR_WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [CNT_WIDTH-1:0]  cnt_i,
  input  logic                  cnt_valid_i,
  output logic                  cnt_ready_o,
  output logic                  cal_valid_o,
  input  logic                  cal_ready_i,
  output logic [YEAR_WIDTH-1:0] year_o,
  output logic [3:0]            month_o,
  output logic [4:0]            mday_o,
  output logic [4:0]            hour_o,
  output logic [5:0]            min_o,
  output logic [5:0]            sec_o,
  output logic [2:0]            wday_o,
  output logic                  busy_o
);

  cal_state_e state_q, state_d;

  logic                  div_start, div_busy, div_done;
  logic [CNT_WIDTH-1:0]  div_dividend, div_divisor, div_quot, div_rem;

  logic [CNT_WIDTH-1:0]  days_q;
  logic [7:0]            yoff_q;
  logic [YEAR_WIDTH-1:0] year_q;
  logic [3:0]            month_q;
  logic [4:0]            mday_q, hour_q;
  logic [5:0]            min_q, sec_q;

  logic                  hs, leap;
  logic [CNT_WIDTH-1:0]  ylen, mlen;

  rtc_cal_div #(.CNT_WIDTH(CNT_WIDTH)) u_div (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (div_start),
    .dividend_i (div_dividend),
    .divisor_i  (div_divisor),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quot_o     (div_quot),
    .rem_o      (div_rem)
  );

  // The divider is always idle in IDLE; the term only guarantees a new
  // start can never land on a divide still in flight.
  assign cnt_ready_o = (state_q == ST_IDLE) && !div_busy;
  assign cal_valid_o = (state_q == ST_DONE);
  assign busy_o      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign hs          = cnt_valid_i && cnt_ready_o;

  // Gregorian rule restricted to 2000..2136: only 2100 breaks the 4-year rule.
  assign leap = (yoff_q[1:0] == 2'b00) && (yoff_q != 8'd100);
  assign ylen = leap ? CNT_WIDTH'(366) : CNT_WIDTH'(365);
  assign mlen = CNT_WIDTH'(month_len(month_q, leap));

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Each divide is started on the edge that enters its state, so the state
  // lasts exactly until the divider's done pulse.
  always_comb begin
    state_d      = state_q;
    div_start    = 1'b0;
    div_dividend = '0;
    div_divisor  = '0;
    case (state_q)
      ST_IDLE: if (hs) begin
        div_start    = 1'b1;
        div_dividend = cnt_i;
        div_divisor  = CNT_WIDTH'(SEC_PER_DAY);
        state_d      = ST_DIV_DAY;
      end
      ST_DIV_DAY: if (div_done) begin
        div_start    = 1'b1;
        div_dividend = div_rem;
        div_divisor  = CNT_WIDTH'(SEC_PER_HR);
        state_d      = ST_DIV_HR;
      end
      ST_DIV_HR: if (div_done) begin
        div_start    = 1'b1;
        div_dividend = div_rem;
        div_divisor  = CNT_WIDTH'(SEC_PER_MIN);
        state_d      = ST_DIV_MIN;
      end
      ST_DIV_MIN: if (div_done) begin
`ifdef RTC_CAL_WDAY_EN
        div_start    = 1'b1;
        div_dividend = days_q + CNT_WIDTH'(EPOCH_WDAY);
        div_divisor  = CNT_WIDTH'(DAYS_PER_WEEK);
        state_d      = ST_DIV_WDAY;
`else
        state_d      = ST_YEAR;
`endif
      end
      ST_DIV_WDAY: if (div_done) state_d = ST_YEAR;
      ST_YEAR:     if (days_q < ylen) state_d = ST_MONTH;
      ST_MONTH:    if (days_q < mlen) state_d = ST_DONE;
      ST_DONE:     if (cal_ready_i) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      days_q  <= '0;
      yoff_q  <= '0;
      year_q  <= '0;
      month_q <= '0;
      mday_q  <= '0;
      hour_q  <= '0;
      min_q   <= '0;
      sec_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (hs) begin
          yoff_q  <= '0;
          month_q <= 4'd1;
        end
        ST_DIV_DAY: if (div_done) days_q <= div_quot;
        ST_DIV_HR:  if (div_done) hour_q <= div_quot[4:0];
        ST_DIV_MIN: if (div_done) begin
          min_q <= div_quot[5:0];
          sec_q <= div_rem[5:0];
        end
        ST_YEAR: if (days_q >= ylen) begin
          days_q <= days_q - ylen;
          yoff_q <= yoff_q + 8'd1;
        end
        ST_MONTH: if (days_q >= mlen) begin
          days_q  <= days_q - mlen;
          month_q <= month_q + 4'd1;
        end else begin
          mday_q <= days_q[4:0] + 5'd1;
          year_q <= YEAR_WIDTH'(EPOCH_YEAR) + YEAR_WIDTH'(yoff_q);
        end
        default: ;
      endcase
    end
  end

`ifdef RTC_CAL_WDAY_EN
  logic [2:0] wday_q;
  always_ff @(posedge clk_i) begin
    if (rst_i)                                    wday_q <= '0;
    else if (state_q == ST_DIV_WDAY && div_done) wday_q <= div_rem[2:0];
  end
  assign wday_o = wday_q;
`else
  assign wday_o = 3'd0;
`endif

  assign year_o  = year_q;
  assign month_o = month_q;
  assign mday_o  = mday_q;
  assign hour_o  = hour_q;
  assign min_o   = min_q;
  assign sec_o   = sec_q;

endmodule

// File: tb/tb_rtc_cal_conv.sv
// Bench for rtc_cal_conv: directed seconds counts with hand-computed calendar results.
// Latency: n/a.
// Backpressure: exercises held results and reset during a conversion.
module tb_rtc_cal_conv;

`ifdef RTC_CAL_WDAY_EN
  localparam int NDIV    = 4;
  localparam bit WDAY_EN = 1'b1;
`else
  localparam int NDIV    = 3;
  localparam bit WDAY_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] cnt_i;
  logic        cnt_valid_i, cnt_ready_o, cal_valid_o, cal_ready_i, busy_o;
  logic [11:0] year_o;
  logic [3:0]  month_o;
  logic [4:0]  mday_o, hour_o;
  logic [5:0]  min_o, sec_o;
  logic [2:0]  wday_o;

  rtc_cal_conv #(.CNT_WIDTH(32), .YEAR_WIDTH(12)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .cnt_i       (cnt_i),
    .cnt_valid_i (cnt_valid_i),
    .cnt_ready_o (cnt_ready_o),
    .cal_valid_o (cal_valid_o),
    .cal_ready_i (cal_ready_i),
    .year_o      (year_o),
    .month_o     (month_o),
    .mday_o      (mday_o),
    .hour_o      (hour_o),
    .min_o       (min_o),
    .sec_o       (sec_o),
    .wday_o      (wday_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] cnt;
    int year, month, mday, hour, mi, sec, wday;
  } vec_t;

  typedef struct {
    vec_t v;
    int   hs;
  } exp_t;

  vec_t vecs[7];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic bound_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  // Present one count and hold valid until the handshake edge.
  task automatic issue(input vec_t v, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    cnt_i       = v.cnt;
    cnt_valid_i = 1'b1;
    while (!cnt_ready_o && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!cnt_ready_o) bound_fail("handshake");
    else if (push) sb.push_back('{v: v, hs: cyc});
    @(negedge clk);
    cnt_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || cal_valid_o) && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) bound_fail("drain");
    @(negedge clk);
  endtask

  // Monitor: compares each new result against the oldest expectation.
  bit   prev_vld = 1'b0;
  bit   chk_drop = 1'b0;
  exp_t e;
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (chk_drop) begin
        check("accept_drop", int'(cal_valid_o), 0);
        chk_drop = 1'b0;
      end
      if (cal_valid_o && !prev_vld) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: got year %0d month %0d, expected no result", year_o, month_o);
        end else begin
          e = sb.pop_front();
          check("year",    int'(year_o),  e.v.year);
          check("month",   int'(month_o), e.v.month);
          check("mday",    int'(mday_o),  e.v.mday);
          check("hour",    int'(hour_o),  e.v.hour);
          check("min",     int'(min_o),   e.v.mi);
          check("sec",     int'(sec_o),   e.v.sec);
          check("wday",    int'(wday_o),  WDAY_EN ? e.v.wday : 0);
          check("latency", cyc - e.hs,    NDIV * 33 + (e.v.year - 2000) + e.v.month + 2);
        end
      end
      chk_drop = cal_valid_o && cal_ready_i;
      prev_vld = cal_valid_o;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit seen;
    vecs[0] = '{32'd0,          2000,  1,  1,  0,  0,  0, 6};
    vecs[1] = '{32'd86399,      2000,  1,  1, 23, 59, 59, 6};
    vecs[2] = '{32'd5097600,    2000,  2, 29,  0,  0,  0, 2};
    vecs[3] = '{32'd3160857600, 2100,  3,  1,  0,  0,  0, 1};
    vecs[4] = '{32'hFFFF_FFFF,  2136,  2,  7,  6, 28, 15, 2};
    vecs[5] = '{32'd31622399,   2000, 12, 31, 23, 59, 59, 0};
    vecs[6] = '{32'd31622400,   2001,  1,  1,  0,  0,  0, 1};

    rst_i       = 1'b1;
    cnt_i       = '0;
    cnt_valid_i = 1'b0;
    cal_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cnt_ready", int'(cnt_ready_o), 1);
    check("rst_cal_valid", int'(cal_valid_o), 0);
    check("rst_busy",      int'(busy_o),      0);
    check("rst_year",      int'(year_o),      0);
    check("rst_month",     int'(month_o),     0);
    rst_i = 1'b0;

    for (int i = 0; i < 7; i++) begin
      issue(vecs[i], 1'b1);
      check("busy_mid",      int'(busy_o),      1);
      check("ready_mid",     int'(cnt_ready_o), 0);
      wait_idle();
    end

    // Result held under backpressure; a new count offered meanwhile is ignored.
    cal_ready_i = 1'b0;
    issue(vecs[2], 1'b1);
    n = 0;
    while (!cal_valid_o && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!cal_valid_o) bound_fail("bp_valid");
    cnt_i       = 32'd12345;
    cnt_valid_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_valid_hold", int'(cal_valid_o), 1);
      check("bp_ready_low",  int'(cnt_ready_o), 0);
      check("bp_mday_hold",  int'(mday_o),      29);
      check("bp_month_hold", int'(month_o),     2);
    end
    cnt_valid_i = 1'b0;
    cal_ready_i = 1'b1;
    wait_idle();

    // Reset in the middle of the hour divide: no result may follow.
    issue(vecs[4], 1'b0);
    repeat (40) @(negedge clk);
    check("pre_rst_busy", int'(busy_o), 1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("mid_rst_cnt_ready", int'(cnt_ready_o), 1);
    check("mid_rst_cal_valid", int'(cal_valid_o), 0);
    check("mid_rst_busy",      int'(busy_o),      0);
    check("mid_rst_year",      int'(year_o),      0);
    seen = 1'b0;
    repeat (320) begin
      @(negedge clk);
      if (cal_valid_o) seen = 1'b1;
    end
    check("no_stale_result", int'(seen), 0);

    issue(vecs[3], 1'b1);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
